// File: rtl/regfile_wb_if.sv
// regfile_wb_if: ALU/LSU result handshakes, write port, issue and hazard/forwarding signals
interface regfile_wb_if;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        lsu_valid;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        lsu_ready;
  logic        wr;
  logic [4:0]  rd;
  logic [31:0] rd_d;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        rs1_busy;
  logic        rs2_busy;
  logic        fwd1_en;
  logic [31:0] fwd1_d;
  logic        fwd2_en;
  logic [31:0] fwd2_d;
  modport master (
    output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
           issue_valid, issue_rd, rs1, rs2,
    input  alu_ready, lsu_ready, wr, rd, rd_d, rs1_busy, rs2_busy,
           fwd1_en, fwd1_d, fwd2_en, fwd2_d
  );
  modport slave (
    input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
           issue_valid, issue_rd, rs1, rs2,
    output alu_ready, lsu_ready, wr, rd, rd_d, rs1_busy, rs2_busy,
           fwd1_en, fwd1_d, fwd2_en, fwd2_d
  );
endinterface

// File: rtl/regfile_wb.sv
// regfile_wb: arbitrates ALU/LSU results onto the register-file write port,
// tracks pending-write busy bits and produces forwarding for the stale-read window
module regfile_wb #(
  parameter int STARVE_MAX = 4
) (
  input logic         clk,
  input logic         rst_n,
  regfile_wb_if.slave bus
);
  logic [3:0]  starve_q, starve_d;
  logic        wr_q, wr_d;
  logic [4:0]  addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [31:0] busy_q, busy_d;
  logic        fwd1_en_q, fwd1_en_d, fwd2_en_q, fwd2_en_d;
  logic [31:0] fwd1_q, fwd1_d, fwd2_q, fwd2_d;
  logic        force_alu, alu_rdy, lsu_rdy, acc;
  logic [4:0]  sel_rd;
  logic [31:0] sel_data, set_mask, clr_mask;
  // LSU normally wins; a starved ALU is forced through once the counter saturates
  always_comb begin
    force_alu = bus.alu_valid && (starve_q == 4'(STARVE_MAX));
    alu_rdy   = bus.alu_valid && (!bus.lsu_valid || force_alu);
    lsu_rdy   = bus.lsu_valid && !alu_rdy;
    acc       = alu_rdy || lsu_rdy;
    sel_rd    = alu_rdy ? bus.alu_rd : bus.lsu_rd;
    sel_data  = alu_rdy ? bus.alu_data : bus.lsu_data;
    starve_d  = (!bus.alu_valid || alu_rdy) ? 4'd0 :
                (starve_q == 4'(STARVE_MAX)) ? starve_q : starve_q + 4'd1;
    wr_d      = acc && (sel_rd != 5'd0);
    addr_d    = acc ? sel_rd : addr_q;
    data_d    = acc ? sel_data : data_q;
    set_mask  = bus.issue_valid ? (32'd1 << bus.issue_rd) : 32'd0;
    clr_mask  = wr_q ? (32'd1 << addr_q) : 32'd0;
    busy_d    = ((busy_q & ~clr_mask) | set_mask) & ~32'd1;
    fwd1_en_d = wr_q && (addr_q != 5'd0) && (addr_q == bus.rs1);
    fwd2_en_d = wr_q && (addr_q != 5'd0) && (addr_q == bus.rs2);
    fwd1_d    = fwd1_en_d ? data_q : fwd1_q;
    fwd2_d    = fwd2_en_d ? data_q : fwd2_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q  <= '0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      busy_q    <= '0;
      fwd1_en_q <= 1'b0;
      fwd2_en_q <= 1'b0;
      fwd1_q    <= '0;
      fwd2_q    <= '0;
    end else begin
      starve_q  <= starve_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      busy_q    <= busy_d;
      fwd1_en_q <= fwd1_en_d;
      fwd2_en_q <= fwd2_en_d;
      fwd1_q    <= fwd1_d;
      fwd2_q    <= fwd2_d;
    end
  end
  assign bus.alu_ready = alu_rdy;
  assign bus.lsu_ready = lsu_rdy;
  assign bus.wr        = wr_q;
  assign bus.rd        = addr_q;
  assign bus.rd_d      = data_q;
  assign bus.rs1_busy  = busy_q[bus.rs1];
  assign bus.rs2_busy  = busy_q[bus.rs2];
  assign bus.fwd1_en   = fwd1_en_q;
  assign bus.fwd1_d    = fwd1_q;
  assign bus.fwd2_en   = fwd2_en_q;
  assign bus.fwd2_d    = fwd2_q;
endmodule

// File: tb/tb_regfile_wb.sv
// tb_regfile_wb: directed checks of arbitration, write port, busy scoreboard, forwarding and reset
module tb_regfile_wb;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  regfile_wb_if bus ();
  regfile_wb #(.STARVE_MAX(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  initial begin
    bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_data = 0;
    bus.lsu_valid = 0; bus.lsu_rd = 0; bus.lsu_data = 0;
    bus.issue_valid = 0; bus.issue_rd = 0; bus.rs1 = 0; bus.rs2 = 0;
    tick(); tick();
    chk("rst_wr", 32'(bus.wr), 0);
    chk("rst_rd", 32'(bus.rd), 0);
    chk("rst_rd_d", bus.rd_d, 0);
    chk("rst_fwd1_en", 32'(bus.fwd1_en), 0);
    chk("rst_fwd2_en", 32'(bus.fwd2_en), 0);
    chk("rst_fwd1_d", bus.fwd1_d, 0);
    chk("rst_fwd2_d", bus.fwd2_d, 0);
    chk("rst_ready", 32'({bus.alu_ready, bus.lsu_ready}), 0);
    chk("rst_busy", 32'({bus.rs1_busy, bus.rs2_busy}), 0);
    rst_n = 1'b1;
    tick();
    // single ALU result
    bus.alu_valid = 1; bus.alu_rd = 5; bus.alu_data = 32'hDEADBEEF;
    #1;
    chk("t1_alu_ready", 32'(bus.alu_ready), 1);
    chk("t1_lsu_ready", 32'(bus.lsu_ready), 0);
    tick();
    bus.alu_valid = 0;
    chk("t1_wr", 32'(bus.wr), 1);
    chk("t1_rd", 32'(bus.rd), 5);
    chk("t1_rd_d", bus.rd_d, 32'hDEADBEEF);
    tick();
    chk("t1_wr_off", 32'(bus.wr), 0);
    chk("t1_rd_hold", 32'(bus.rd), 5);
    chk("t1_rd_d_hold", bus.rd_d, 32'hDEADBEEF);
    // starvation: LSU wins cycles 0-3, ALU forced in 4, LSU again in 5
    bus.alu_valid = 1; bus.alu_rd = 1; bus.alu_data = 32'h000000A1;
    bus.lsu_valid = 1; bus.lsu_rd = 2; bus.lsu_data = 32'h000000B2;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk($sformatf("t2_alu_ready_c%0d", c), 32'(bus.alu_ready), (c == 4) ? 1 : 0);
      chk($sformatf("t2_lsu_ready_c%0d", c), 32'(bus.lsu_ready), (c == 4) ? 0 : 1);
      if (c > 0) chk($sformatf("t2_rd_c%0d", c), 32'(bus.rd), (c == 5) ? 1 : 2);
      tick();
    end
    bus.alu_valid = 0; bus.lsu_valid = 0;
    chk("t2_last_rd", 32'(bus.rd), 2);
    chk("t2_last_data", bus.rd_d, 32'h000000B2);
    tick();
    // rd==0 result is consumed without a write
    bus.alu_valid = 1; bus.alu_rd = 0; bus.alu_data = 32'h12345678;
    #1;
    chk("t3_alu_ready", 32'(bus.alu_ready), 1);
    tick();
    bus.alu_valid = 0;
    chk("t3_wr", 32'(bus.wr), 0);
    chk("t3_busy0", 32'(bus.rs1_busy), 0);
    tick();
    // busy scoreboard on r7
    bus.issue_valid = 1; bus.issue_rd = 7;
    tick();
    bus.issue_valid = 0; bus.rs1 = 7;
    #1;
    chk("t4_busy_c1", 32'(bus.rs1_busy), 1);
    tick();
    chk("t4_busy_c2", 32'(bus.rs1_busy), 1);
    tick();
    bus.alu_valid = 1; bus.alu_rd = 7; bus.alu_data = 32'h00000077;
    tick();
    bus.alu_valid = 0; bus.issue_valid = 1; bus.issue_rd = 7;
    chk("t4_wr_c4", 32'(bus.wr), 1);
    chk("t4_rd_c4", 32'(bus.rd), 7);
    chk("t4_busy_c4", 32'(bus.rs1_busy), 1);
    tick();
    bus.issue_valid = 0;
    chk("t4_busy_setwins", 32'(bus.rs1_busy), 1);
    chk("t4_fwd1_en_c5", 32'(bus.fwd1_en), 1);
    chk("t4_fwd1_d_c5", bus.fwd1_d, 32'h00000077);
    bus.alu_valid = 1; bus.alu_rd = 7; bus.alu_data = 32'h00000078;
    tick();
    bus.alu_valid = 0;
    chk("t4_busy_c6", 32'(bus.rs1_busy), 1);
    chk("t4_fwd1_en_c6", 32'(bus.fwd1_en), 0);
    tick();
    chk("t4_busy_clear", 32'(bus.rs1_busy), 0);
    chk("t4_fwd1_d_c7", bus.fwd1_d, 32'h00000078);
    // forwarding to rs1 only
    bus.rs1 = 9; bus.rs2 = 3;
    bus.alu_valid = 1; bus.alu_rd = 9; bus.alu_data = 32'hCAFEF00D;
    tick();
    bus.alu_valid = 0;
    chk("t5_wr", 32'(bus.wr), 1);
    tick();
    chk("t5_fwd1_en", 32'(bus.fwd1_en), 1);
    chk("t5_fwd1_d", bus.fwd1_d, 32'hCAFEF00D);
    chk("t5_fwd2_en", 32'(bus.fwd2_en), 0);
    chk("t5_fwd2_d_hold", bus.fwd2_d, 0);
    tick();
    chk("t5_fwd1_en_off", 32'(bus.fwd1_en), 0);
    chk("t5_fwd1_d_hold", bus.fwd1_d, 32'hCAFEF00D);
    // mid-cycle reset drops an in-flight write
    bus.rs1 = 4; bus.rs2 = 4;
    bus.issue_valid = 1; bus.issue_rd = 4;
    bus.alu_valid = 1; bus.alu_rd = 4; bus.alu_data = 32'h00000044;
    tick();
    bus.issue_valid = 0; bus.alu_valid = 0;
    chk("t6_wr_pre", 32'(bus.wr), 1);
    chk("t6_busy_pre", 32'(bus.rs1_busy), 1);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_wr_rst", 32'(bus.wr), 0);
    chk("t6_rd_rst", 32'(bus.rd), 0);
    chk("t6_rd_d_rst", bus.rd_d, 0);
    chk("t6_busy_rst", 32'(bus.rs1_busy), 0);
    chk("t6_fwd_rst", 32'({bus.fwd1_en, bus.fwd2_en}), 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t6_no_replay_wr", 32'(bus.wr), 0);
    chk("t6_no_replay_fwd", 32'(bus.fwd1_en), 0);
    tick();
    chk("t6_no_replay_wr2", 32'(bus.wr), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
